// File: rtl/display_scan_controller_pkg.sv
// disp_pkg: shared digit count, anode-off pattern, field widths and active-low one-hot anode helper
package disp_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int S_W = 2;
  localparam int NIB_W = 4;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;
  function automatic logic [NUM_DIGITS-1:0] an_onehot_low(input logic [S_W-1:0] s);
    return ~(4'b0001 << s);
  endfunction
endpackage

// File: rtl/display_scan_controller_if.sv
// display_scan_controller_if: load handshake bundle; master drives load_valid/load_data/load_mask, slave returns load_ready
interface display_scan_controller_if;
  import disp_pkg::*;
  logic load_valid;
  logic [NUM_DIGITS*NIB_W-1:0] load_data;
  logic [NUM_DIGITS-1:0] load_mask;
  logic load_ready;
  modport master(output load_valid, load_data, load_mask, input load_ready);
  modport slave(input load_valid, load_data, load_mask, output load_ready);
endinterface

// File: rtl/display_scan_controller_slot_prescaler.sv
// slot_prescaler: counts clk/reset cycles 0..REFRESH_DIV-1, outputs cnt and slot_tick on the last cycle of each slot
module slot_prescaler #(
  parameter int REFRESH_DIV = 100000,
  localparam int CW = $clog2(REFRESH_DIV)
) (
  input  logic          clk,
  input  logic          reset,
  output logic [CW-1:0] cnt,
  output logic          slot_tick
);
  logic [CW-1:0] cnt_d, cnt_q;
  always_comb begin
    slot_tick = cnt_q == CW'(REFRESH_DIV - 1);
    cnt_d = slot_tick ? '0 : cnt_q + CW'(1);
  end
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign cnt = cnt_q;
endmodule

// File: rtl/display_scan_controller.sv
// display_scan_controller: 4-digit scan (clk, reset, ld slave handshake -> AN, S, nibble, frame_done) with frame-aligned word commit
module display_scan_controller
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                   clk,
  input  logic                   reset,
  display_scan_controller_if.slave ld,
  output logic [NUM_DIGITS-1:0]  AN,
  output logic [S_W-1:0]         S,
  output logic [NIB_W-1:0]       nibble,
  output logic                   frame_done
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int DW = NUM_DIGITS * NIB_W;
  logic [CW-1:0] cnt;
  logic slot_tick, accept, commit, blank;
  logic [S_W-1:0] s_d, s_q;
  logic [DW-1:0] act_data_d, act_data_q, pend_data_d, pend_data_q;
  logic [NUM_DIGITS-1:0] act_mask_d, act_mask_q, pend_mask_d, pend_mask_q;
  logic pending_d, pending_q;
  slot_prescaler #(.REFRESH_DIV(REFRESH_DIV)) u_pre (
    .clk(clk), .reset(reset), .cnt(cnt), .slot_tick(slot_tick)
  );
  always_comb begin
    frame_done = slot_tick && s_q == S_W'(NUM_DIGITS - 1);
    ld.load_ready = !pending_q;
    accept = ld.load_valid && !pending_q;
    commit = frame_done && pending_q;
    s_d = slot_tick ? s_q + S_W'(1) : s_q;
    pend_data_d = accept ? ld.load_data : pend_data_q;
    pend_mask_d = accept ? ld.load_mask : pend_mask_q;
    pending_d = accept ? 1'b1 : commit ? 1'b0 : pending_q;
    act_data_d = commit ? pend_data_q : act_data_q;
    act_mask_d = commit ? pend_mask_q : act_mask_q;
    blank = 32'(cnt) < BLANK_CYCLES;
    AN = (blank || !act_mask_q[s_q]) ? AN_OFF : an_onehot_low(s_q);
    nibble = act_data_q[NIB_W*s_q +: NIB_W];
    S = s_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s_q <= '0;
      act_data_q <= '0;
      act_mask_q <= '0;
      pend_data_q <= '0;
      pend_mask_q <= '0;
      pending_q <= 1'b0;
    end else begin
      s_q <= s_d;
      act_data_q <= act_data_d;
      act_mask_q <= act_mask_d;
      pend_data_q <= pend_data_d;
      pend_mask_q <= pend_mask_d;
      pending_q <= pending_d;
    end
  end
endmodule
